loop_replay_ram: RTL and testbench
==================================

Name: loop_replay_ram

Overview:
Parametrised write-once, replay-many RAM for the xg_interface data path. Software or the upstream block loads a frame image word-by-word at arbitrary addresses. The block tracks the loaded length and, on start, streams the image out 1..N times or endlessly. The output is a valid/ready stream with first/last markers, backpressure support and a completion pulse. It generalises the earlier single-pass loop RAM with length tracking, repeat count, continuous mode, abort and backpressure.

Parameters:
WIDTH, 417, data word width in bits
DEPTH_BITS, 6, address width; capacity = 2**DEPTH_BITS words
CNT_BITS, 16, width of repeat counter

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
clr  in  1  clears recorded length to 0 (IDLE only)
wr_en  in  1  write strobe
wr_addr  in  DEPTH_BITS  write address
din  in  WIDTH  write data
start  in  1  begin replay (sampled in IDLE only)
stop  in  1  abort replay
loop_cnt  in  CNT_BITS  passes to play; 0 = continuous until stop; latched on start
dout  out  WIDTH  output word
out_valid  out  1  dout valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_first  out  1  dout is address 0 of a pass
out_last  out  1  dout is address length-1 of a pass
busy  out  1  replay in progress
done  out  1  one-cycle pulse on normal completion
length  out  DEPTH_BITS+1  words recorded = highest written address + 1
full  out  1  length == 2**DEPTH_BITS
wr_err  out  1  one-cycle pulse: write attempted while busy (write dropped)

Behaviour:
- Reset: state IDLE; length=0; out_valid, out_first, out_last, busy, done, wr_err=0; dout=0. RAM contents not cleared.
- Length tracking: on an accepted write, length <= max(length, wr_addr+1), computed in DEPTH_BITS+1 bits with no wrap. clr and wr_en in the same cycle: clear first, then write, so length=wr_addr+1. Rewriting a lower address leaves length unchanged.
- Writes and clr are accepted only in IDLE. While busy, a write is dropped and wr_err pulses the next cycle; clr is ignored.
- RAM: simple dual-port, synchronous read, 1-cycle read latency. dout is registered.
- States: IDLE, FETCH, PLAY.
  - IDLE: start && length>0 -> FETCH. Latch loop_cnt into pass counter, rd_addr=0, busy=1 from next cycle.
  - IDLE: start && length==0 -> stay IDLE, done pulses the next cycle, no output.
  - FETCH: issue read of rd_addr -> PLAY.
  - PLAY: out_valid=1. On transfer, advance rd_addr; wrap to 0 after length-1 and decrement the pass counter (skip the decrement when continuous). The next word is prefetched so back-to-back transfers sustain 1 word/clk with out_ready held high.
- Latency: first out_valid exactly 2 cycles after start is sampled.
- Backpressure: while out_valid && !out_ready, dout, out_first and out_last hold stable and rd_addr does not advance.
- Markers: out_first=1 on address 0; out_last=1 on address length-1. Both are 1 when length==1.
- Completion: on the transfer of out_last with the pass counter ==1 (non-continuous), the next cycle has out_valid=0, busy=0, done=1 and state IDLE.
- stop (any state other than IDLE): next cycle out_valid=0, busy=0, state IDLE. done is not pulsed. A transfer coinciding with stop counts as taken. stop in IDLE has no effect. stop has priority over a simultaneous start.
- Reset mid-replay: immediate return to the reset values above; length is cleared.
- out_valid is never asserted in IDLE or FETCH.

Test Plan:
1. Write D0..D3 at addresses 0..3, loop_cnt=2, out_ready=1, pulse start at cycle T -> out_valid from T+2; 8 words D0,D1,D2,D3,D0,D1,D2,D3 on consecutive cycles; out_first on words 1 and 5; out_last on words 4 and 8; done=1 at T+10; busy=0 from T+10; length=4.
2. Same image, loop_cnt=1, out_ready low every other cycle -> dout and out_last stay stable while stalled; exactly 4 transfers in order; single done pulse.
3. Single write at address 0 (length=1), loop_cnt=3 -> 3 transfers of D0, each with out_first=out_last=1; then done.
4. loop_cnt=0, length=4, run 20 transfers, then assert stop -> sequence D0..D3 repeating; out_valid=0 the cycle after stop; no done pulse; busy=0.
5. Write at address 5 during replay -> wr_err pulses; after return to IDLE, length unchanged and RAM address 5 holds its old data. Then clr with wr_en to address 2 in the same cycle -> length=3.
6. DEPTH_BITS=3: write address 7 -> length=8, full=1. Start with length 0 after clr -> done next cycle, out_valid never asserted. Assert reset mid-replay -> all outputs return to reset values, length=0.

Source files
------------

// File: rtl/loop_replay_ram_if.sv
// loop_replay_ram_if: bundles the write port, replay control and output stream of
// loop_replay_ram. Ports: clr/wr_en/wr_addr/din (image load), start/stop/loop_cnt
// (replay control), dout/out_valid/out_ready/out_first/out_last (stream),
// busy/done/length/full/wr_err (status). master = producer/consumer side, slave = RAM.
interface loop_replay_ram_if #(
  parameter int unsigned WIDTH      = 417,
  parameter int unsigned DEPTH_BITS = 6,
  parameter int unsigned CNT_BITS   = 16
);
  logic                  clr;
  logic                  wr_en;
  logic [DEPTH_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]      din;
  logic                  start;
  logic                  stop;
  logic [CNT_BITS-1:0]   loop_cnt;
  logic [WIDTH-1:0]      dout;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [DEPTH_BITS:0]   length;
  logic                  full;
  logic                  wr_err;

  modport master (
    output clr, wr_en, wr_addr, din, start, stop, loop_cnt, out_ready,
    input  dout, out_valid, out_first, out_last, busy, done, length, full, wr_err
  );

  modport slave (
    input  clr, wr_en, wr_addr, din, start, stop, loop_cnt, out_ready,
    output dout, out_valid, out_first, out_last, busy, done, length, full, wr_err
  );
endinterface

// File: rtl/loop_replay_ram.sv
// loop_replay_ram: write-once, replay-many frame RAM. An image is loaded word by word
// in IDLE (length = highest written address + 1); start streams it out loop_cnt times
// (0 = until stop) as a valid/ready stream with first/last markers and a done pulse.
// Ports: clk, reset (synchronous, active-high), bus (loop_replay_ram_if.slave).
module loop_replay_ram #(
  parameter int unsigned WIDTH      = 417,
  parameter int unsigned DEPTH_BITS = 6,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic             clk,
  input  logic             reset,
  loop_replay_ram_if.slave bus
);
  localparam int unsigned LEN_BITS = DEPTH_BITS + 1;
  localparam int unsigned DEPTH    = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [DEPTH_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_BITS-1:0]   pass_q, pass_d;
  logic [LEN_BITS-1:0]   length_q, length_d;
  logic                  full_q, full_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_first_q, out_first_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;
  logic [WIDTH-1:0]      dout_q;

  logic                  wr_ok_c;
  logic                  rd_en_c;
  logic [DEPTH_BITS-1:0] rd_sel_c;
  logic [LEN_BITS-1:0]   len_base_c;
  logic [LEN_BITS-1:0]   wr_len_c;
  logic [LEN_BITS-1:0]   last_addr_c;
  logic                  xfer_c;
  logic                  at_last_c;
  logic                  cont_c;

  // Next-state, length tracking and replay sequencing
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    pass_d      = pass_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    rd_en_c     = 1'b0;
    rd_sel_c    = rd_addr_q;

    // Loads only land in IDLE; clr applies before a same-cycle write
    wr_ok_c    = bus.wr_en && (state_q == IDLE);
    wr_err_d   = bus.wr_en && (state_q != IDLE);
    len_base_c = (bus.clr && (state_q == IDLE)) ? '0 : length_q;
    wr_len_c   = LEN_BITS'(bus.wr_addr) + LEN_BITS'(1);
    length_d   = len_base_c;
    if (wr_ok_c && (wr_len_c > len_base_c)) length_d = wr_len_c;

    last_addr_c = length_q - LEN_BITS'(1);
    cont_c      = (pass_q == '0);
    xfer_c      = out_valid_q && bus.out_ready;
    at_last_c   = (LEN_BITS'(rd_addr_q) == last_addr_c);

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (length_q != '0) begin
            state_d   = FETCH;
            rd_addr_d = '0;
            pass_d    = bus.loop_cnt;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        rd_en_c     = 1'b1;
        out_valid_d = 1'b1;
        out_first_d = (rd_addr_q == '0);
        out_last_d  = at_last_c;
        state_d     = PLAY;
      end
      PLAY: begin
        if (xfer_c) begin
          if (at_last_c && !cont_c && (pass_q == CNT_BITS'(1))) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            if (at_last_c) begin
              rd_addr_d = '0;
              if (!cont_c) pass_d = pass_q - CNT_BITS'(1);
            end else begin
              rd_addr_d = rd_addr_q + DEPTH_BITS'(1);
            end
            // Fetch the following word on the accepting edge to keep 1 word/clk
            rd_en_c     = 1'b1;
            rd_sel_c    = rd_addr_d;
            out_first_d = (rd_addr_d == '0);
            out_last_d  = (LEN_BITS'(rd_addr_d) == last_addr_c);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything while a replay is active
    if ((state_q != IDLE) && bus.stop) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
      rd_en_c     = 1'b0;
    end

    busy_d = (state_d != IDLE);
    full_d = (length_d == LEN_BITS'(DEPTH));
  end

  // State and output registers; synchronous read port feeds dout directly
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      pass_q      <= '0;
      length_q    <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      pass_q      <= pass_d;
      length_q    <= length_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
      if (rd_en_c) dout_q <= mem[rd_sel_c];
    end
  end

  // Write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[bus.wr_addr] <= bus.din;
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.length    = length_q;
  assign bus.full      = full_q;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_loop_replay_ram.sv
// tb_loop_replay_ram: table-driven replay scenarios plus hand-written corner sequences;
// expected stream words are queued on start and popped as the DUT transfers them.
module tb_loop_replay_ram;
  localparam int unsigned WIDTH = 417;
  localparam int unsigned DB    = 3;
  localparam int unsigned CB    = 16;
  localparam int unsigned DEPTH = 1 << DB;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t data;
    logic  first;
    logic  last;
  } exp_t;
  typedef struct {
    int unsigned len;
    int unsigned cnt;
    bit          stall;
    int unsigned exp_xfers;
    bit          exp_full;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  loop_replay_ram_if #(.WIDTH(WIDTH), .DEPTH_BITS(DB), .CNT_BITS(CB)) bus ();
  loop_replay_ram #(.WIDTH(WIDTH), .DEPTH_BITS(DB), .CNT_BITS(CB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int    tests = 0;
  int    fails = 0;
  exp_t  sbq[$];
  word_t model [DEPTH];
  int    xfers = 0;
  int    done_cnt = 0;
  exp_t  e;
  bit    hold_v = 1'b0;
  word_t hold_d;
  logic  hold_f, hold_l;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(string name, word_t act, word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t rand_word();
    word_t w = '0;
    for (int j = 0; j < 14; j++) w = (w << 32) | word_t'($urandom);
    return w;
  endfunction

  // Stream monitor: scoreboard pops, stall stability, valid only while busy
  always @(negedge clk) begin
    done_cnt += int'(bus.done);
    if (hold_v && bus.out_valid) begin
      check_w("stall_dout", bus.dout, hold_d);
      check("stall_first", 32'(bus.out_first), 32'(hold_f));
      check("stall_last", 32'(bus.out_last), 32'(hold_l));
    end
    if (bus.out_valid) check("valid_while_busy", 32'(bus.busy), 1);
    if (bus.out_valid && bus.out_ready) begin
      xfers++;
      check("sb_empty_at_xfer", 32'(sbq.size() == 0), 0);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check_w("dout", bus.dout, e.data);
        check("out_first", 32'(bus.out_first), 32'(e.first));
        check("out_last", 32'(bus.out_last), 32'(e.last));
      end
    end
    hold_v = bus.out_valid && !bus.out_ready;
    hold_d = bus.dout;
    hold_f = bus.out_first;
    hold_l = bus.out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(int unsigned a, word_t d, logic c);
    bus.wr_en   = 1'b1;
    bus.clr     = c;
    bus.wr_addr = DB'(a);
    bus.din     = d;
    tick();
    bus.wr_en = 1'b0;
    bus.clr   = 1'b0;
    model[a]  = d;
  endtask

  // Highest address first (with clr), then the rest: lower rewrites must not move length
  task automatic load(int unsigned len);
    wr_word(len - 1, rand_word(), 1'b1);
    for (int unsigned a = 0; a + 1 < len; a++) wr_word(a, rand_word(), 1'b0);
  endtask

  task automatic push_passes(int unsigned len, int unsigned passes);
    for (int unsigned p = 0; p < passes; p++)
      for (int unsigned a = 0; a < len; a++)
        sbq.push_back('{data: model[a], first: (a == 0), last: (a == len - 1)});
  endtask

  task automatic run_replay(vec_t v);
    int cyc;
    push_passes(v.len, v.cnt);
    xfers = 0;
    done_cnt = 0;
    bus.out_ready = 1'b1;
    bus.loop_cnt  = CB'(v.cnt);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fetch_no_valid", 32'(bus.out_valid), 0);
    check("busy_after_start", 32'(bus.busy), 1);
    tick();
    check("first_valid_latency", 32'(bus.out_valid), 1);
    cyc = 0;
    while (!bus.done && cyc < 200) begin
      if (v.stall) bus.out_ready = ~bus.out_ready;
      tick();
      cyc++;
    end
    check("done_seen", 32'(bus.done), 1);
    if (!v.stall) check("done_time", 32'(cyc), v.exp_xfers);
    check("busy_at_done", 32'(bus.busy), 0);
    check("valid_at_done", 32'(bus.out_valid), 0);
    check("xfer_count", 32'(xfers), v.exp_xfers);
    check("sb_drained", 32'(sbq.size()), 0);
    check("length_after", 32'(bus.length), v.len);
    bus.out_ready = 1'b1;
    tick();
    check("done_single_pulse", 32'(bus.done), 0);
    check("done_count", 32'(done_cnt), 1);
    sbq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   cyc;
    vecs[0] = '{len: 4, cnt: 2, stall: 1'b0, exp_xfers: 8, exp_full: 1'b0};
    vecs[1] = '{len: 4, cnt: 1, stall: 1'b1, exp_xfers: 4, exp_full: 1'b0};
    vecs[2] = '{len: 1, cnt: 3, stall: 1'b0, exp_xfers: 3, exp_full: 1'b0};
    vecs[3] = '{len: 8, cnt: 1, stall: 1'b0, exp_xfers: 8, exp_full: 1'b1};
    vecs[4] = '{len: 3, cnt: 2, stall: 1'b1, exp_xfers: 6, exp_full: 1'b0};

    reset = 1'b1;
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.din = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_cnt = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_length", 32'(bus.length), 0);
    check("rst_full", 32'(bus.full), 0);
    check_w("rst_dout", bus.dout, '0);

    // Replay scenarios
    foreach (vecs[i]) begin
      load(vecs[i].len);
      check("load_length", 32'(bus.length), vecs[i].len);
      check("load_full", 32'(bus.full), 32'(vecs[i].exp_full));
      run_replay(vecs[i]);
    end

    // Continuous mode, stop after 20 transfers; the stop-cycle transfer counts
    load(4);
    push_passes(4, 6);
    xfers = 0;
    done_cnt = 0;
    bus.loop_cnt = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (xfers < 20 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("cont_reached_20", 32'(xfers), 20);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_valid", 32'(bus.out_valid), 0);
    check("stop_busy", 32'(bus.busy), 0);
    check("stop_no_done", 32'(bus.done), 0);
    check("stop_xfers", 32'(xfers), 21);
    check("stop_sb_left", 32'(sbq.size()), 3);
    sbq.delete();
    tick();
    check("stop_done_count", 32'(done_cnt), 0);

    // Write while busy is dropped and flagged; address 5 keeps its old word
    load(6);
    push_passes(6, 1);
    xfers = 0;
    bus.loop_cnt = CB'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.wr_en = 1'b1; bus.wr_addr = DB'(5); bus.din = rand_word();
    tick();
    bus.wr_en = 1'b0;
    check("wr_err_pulse", 32'(bus.wr_err), 1);
    tick();
    check("wr_err_clear", 32'(bus.wr_err), 0);
    cyc = 0;
    while (!bus.done && cyc < 50) begin
      tick();
      cyc++;
    end
    check("wr_err_run_done", 32'(bus.done), 1);
    check("wr_err_length", 32'(bus.length), 6);
    check("wr_err_sb_drained", 32'(sbq.size()), 0);
    tick();

    // clr and write in one cycle: clear first, then the write sets length
    wr_word(2, rand_word(), 1'b1);
    check("clr_wr_length", 32'(bus.length), 3);

    // stop beats a simultaneous start in IDLE
    bus.start = 1'b1; bus.stop = 1'b1; bus.loop_cnt = CB'(1);
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("stop_start_busy", 32'(bus.busy), 0);
    check("stop_start_done", 32'(bus.done), 0);
    tick();
    check("stop_start_valid", 32'(bus.out_valid), 0);

    // Start with nothing recorded: immediate done, no stream
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_length", 32'(bus.length), 0);
    xfers = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("empty_done", 32'(bus.done), 1);
    check("empty_busy", 32'(bus.busy), 0);
    tick();
    check("empty_done_clear", 32'(bus.done), 0);
    repeat (2) tick();
    check("empty_no_xfer", 32'(xfers), 0);

    // Reset in the middle of a continuous replay
    load(4);
    push_passes(4, 10);
    bus.loop_cnt = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    check("pre_reset_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_first", 32'(bus.out_first), 0);
    check("mid_rst_last", 32'(bus.out_last), 0);
    check("mid_rst_length", 32'(bus.length), 0);
    check("mid_rst_full", 32'(bus.full), 0);
    check("mid_rst_wr_err", 32'(bus.wr_err), 0);
    check_w("mid_rst_dout", bus.dout, '0);
    reset = 1'b0;
    sbq.delete();
    repeat (3) tick();
    check("post_rst_idle", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
